idecode_issue_unit: RTL and testbench
=====================================

# idecode_issue_unit

Instruction-decode/issue stage that produces the 92-bit `idecode_cu_interface` bus consumed by the microprogrammed control unit. It buffers fetched instructions in a 2-entry FIFO and maps each opcode to a microcode start address and count through a loadable map table. It performs static branch prediction with redirect to fetch. The unit advances one instruction per cycle in which the CU signals readiness, and emits a NOP bubble when it has nothing to issue.

## Interface
- `BRANCH_OPCODE`, 6'h04, opcode value (`instr[31:26]`) that identifies a conditional branch
- `BUBBLE_ADDR`, 8'hFF, microcode address driven for a bubble and for unmapped opcodes
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush_pipeline`  in  1  synchronous flush from branch resolution
- `fetch_valid`  in  1  fetch offers `fetch_instr`/`fetch_pc`
- `fetch_instr`  in  32  fetched instruction
- `fetch_pc`  in  8  address of `fetch_instr`
- `fetch_ready`  out  1  FIFO can accept; transfer when `fetch_valid & fetch_ready`
- `cu_ready`  in  1  driven from CU `o_exec_ready_combined`; CU samples the bus on every edge where this is high
- `map_we`  in  1  write strobe for the opcode map
- `map_opcode`  in  6  map entry index
- `map_data`  in  11  {cnt[2:0], addr[7:0]}
- `idecode_cu_interface`  out  92  registered issue bus (fields below)
- `redirect_valid`  out  1  one-cycle pulse: fetch must jump
- `redirect_pc`  out  8  predicted-taken target

## Operation
- Bus fields: [31:0] instr; [39:32] microcode addr; [42:40] microcode cnt; [74:43] reserved, always 0; [82:75] address of path not predicted; [90:83] branch instruction pc; [91] prediction (1 = taken).
- Bubble value: instr 0, addr `BUBBLE_ADDR`, cnt 0, all other fields 0.
- Map table: 64 x 11 bits. Reset sets every entry to {0, `BUBBLE_ADDR`}. A write takes effect on the next edge. A same-cycle write and decode of the same opcode uses the old entry.
- Issue: on an edge with `cu_ready` = 1, the output register loads the decoded FIFO head and pops it. If the FIFO is empty, the output register loads the bubble. With `cu_ready` = 0, the output register and FIFO head hold.
- FIFO: depth 2. `fetch_ready` = (count < 2). Push and pop in the same cycle are legal and leave count unchanged. When count = 2 there is no push. Pointers wrap mod 2.
- Branch (opcode == `BRANCH_OPCODE`):
  - target = fetch_pc + sext(instr[7:0]), mod 256; fallthrough = pc + 1, mod 256 (8'hFF wraps to 8'h00).
  - Prediction taken iff instr[7] = 1 (backward).
  - Field [82:75] = fallthrough if predicted taken, else target.
  - Field [90:83] = pc.
- Non-branch: fields [91:75] are 0.
- Redirect: when a predicted-taken branch is issued, `redirect_valid` = 1 for exactly the next cycle with `redirect_pc` = target. Any FIFO entry younger than that branch is discarded on the same issue edge.
- Flush: `flush_pipeline` = 1 empties the FIFO, loads the bubble into the output register, and clears `redirect_valid`. It overrides issue and push in that cycle. The map table is retained.
- Reset: all outputs are bubble/0, `fetch_ready` = 1 after reset release, map table reset as above. Reset has priority over flush.

## Timing
- Fetch-to-bus latency: 1 cycle minimum (push edge N, issue edge N+1 if `cu_ready`).
- Throughput: 1 instruction/cycle while `cu_ready` stays high.
- `redirect_valid` is registered and asserts in the cycle after the issue edge. It never asserts two cycles in a row.
- `fetch_ready` is combinational from registered count only; there is no combinational path from `cu_ready`.

## Configuration
- `IDECODE_BPRED_EN` defined: static backward-taken prediction and redirect as above.
- Not defined: every branch is predicted not-taken. Field [91] = 0, field [82:75] = target, `redirect_valid`/`redirect_pc` are tied 0, and there is no younger-entry discard.

## Structure
- `idecode_pkg`: bus field offsets/widths, bubble constant, opcode field position, map-entry struct {cnt, addr}.
- Sub-module `idecode_fifo2`: 2-entry valid/ready FIFO carrying {pc, instr}.
- Map table, decode, prediction and output register live in the top module.

## Test plan
- Reset, then `cu_ready` = 1 with no fetch -> bus = bubble every cycle (addr 8'hFF, cnt 0), `fetch_ready` = 1.
- Map opcode 6'h01 -> {3, 8'h20}; push instr 32'h0400_0000 at pc 8'h10 -> next `cu_ready` edge bus addr 8'h20, cnt 3, instr 32'h0400_0000, [91:75] = 0.
- Hold `cu_ready` = 0, push 3 instructions -> `fetch_ready` drops after 2, bus holds; raise `cu_ready` -> issued in order, none lost.
- With `IDECODE_BPRED_EN`, branch at pc 8'h05 with offset 8'hFC -> [91] = 1, [90:83] = 8'h05, [82:75] = 8'h06, next cycle `redirect_valid` = 1 with `redirect_pc` 8'h01, younger entry dropped.
- Forward branch at pc 8'hFF with offset 8'h02 -> [91] = 0, [82:75] = 8'h01, no redirect.
- `flush_pipeline` with FIFO full and simultaneous `fetch_valid` -> FIFO empty, bus bubble, nothing pushed, map entries intact.

Source files
------------

// File: rtl/idecode_pkg.sv
// Shared types and constants for the instruction decode/issue stage.
// Consumed by idecode_fifo2 and idecode_issue_unit.
package idecode_pkg;

    localparam int BUS_W   = 92;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 8;
    localparam int OPC_LSB = 26;
    localparam int OPC_W   = 6;

    localparam logic [OPC_W-1:0] BRANCH_OPCODE_DEF = 6'h04;
    localparam logic [7:0]       BUBBLE_ADDR_DEF   = 8'hFF;

    typedef struct packed {
        logic [2:0] cnt;
        logic [7:0] addr;
    } map_entry_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Field order from MSB down matches the CU's 92-bit bus layout.
    typedef struct packed {
        logic               pred;
        logic [PC_W-1:0]    br_pc;
        logic [PC_W-1:0]    alt_pc;
        logic [31:0]        rsvd;
        logic [2:0]         cnt;
        logic [7:0]         addr;
        logic [INSTR_W-1:0] instr;
    } issue_bus_t;

    function automatic issue_bus_t bubble_bus(input logic [7:0] addr);
        issue_bus_t b;
        b      = '0;
        b.addr = addr;
        return b;
    endfunction

endpackage

// File: rtl/idecode_fifo2.sv
// Two-entry valid/ready FIFO carrying {pc, instr} from fetch to decode.
// A clear drops every entry and any push offered in the same cycle.
module idecode_fifo2
    import idecode_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push_valid,
    input  fetch_entry_t push_data,
    output logic         push_ready,
    input  logic         pop,
    output logic         head_valid,
    output fetch_entry_t head_data
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign push_ready = (count < 2'd2);
    assign head_valid = (count != 2'd0);
    assign head_data  = mem[rd_ptr];
    assign do_push    = push_valid & push_ready;
    assign do_pop     = pop & head_valid;

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    // NOTE: payload storage has no reset; count gates its visibility, so stale data is never issued.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/idecode_issue_unit.sv
// Decode/issue stage: opcode map table, static branch prediction and the registered CU bus.
// Define IDECODE_BPRED_EN for backward-taken prediction with fetch redirect.
module idecode_issue_unit
    import idecode_pkg::*;
#(
    parameter logic [OPC_W-1:0] BRANCH_OPCODE = BRANCH_OPCODE_DEF,
    parameter logic [7:0]       BUBBLE_ADDR   = BUBBLE_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_pipeline,
    input  logic               fetch_valid,
    input  logic [31:0]        fetch_instr,
    input  logic [7:0]         fetch_pc,
    output logic               fetch_ready,
    input  logic               cu_ready,
    input  logic               map_we,
    input  logic [5:0]         map_opcode,
    input  logic [10:0]        map_data,
    output logic [BUS_W-1:0]   idecode_cu_interface,
    output logic               redirect_valid,
    output logic [7:0]         redirect_pc
);

    map_entry_t   map_q [64];
    fetch_entry_t head;
    logic         head_valid;
    map_entry_t   entry;
    logic         is_branch;
    logic         predict_taken;
    logic [7:0]   target;
    logic [7:0]   alt_pc;
    logic         issue_pop;
    logic         discard;
    issue_bus_t   dec_bus;
    issue_bus_t   bus_q;

    // The map is architectural state the CU depends on, so every entry is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) map_q[i] <= '{cnt: 3'd0, addr: BUBBLE_ADDR};
        end else if (map_we) begin
            map_q[map_opcode] <= map_entry_t'(map_data);
        end
    end

    idecode_fifo2 u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (flush_pipeline | discard),
        .push_valid (fetch_valid),
        .push_data  ('{pc: fetch_pc, instr: fetch_instr}),
        .push_ready (fetch_ready),
        .pop        (issue_pop),
        .head_valid (head_valid),
        .head_data  (head)
    );

    assign entry     = map_q[head.instr[OPC_LSB +: OPC_W]];
    assign is_branch = (head.instr[OPC_LSB +: OPC_W] == BRANCH_OPCODE);
    assign target    = head.pc + head.instr[7:0];

`ifdef IDECODE_BPRED_EN
    assign predict_taken = is_branch & head.instr[7];
    assign alt_pc        = predict_taken ? head.pc + 8'd1 : target;
`else
    assign predict_taken = 1'b0;
    assign alt_pc        = target;
`endif

    assign issue_pop = cu_ready & ~flush_pipeline & head_valid;
    assign discard   = issue_pop & predict_taken;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_bus = bubble_bus(BUBBLE_ADDR);
        if (head_valid) begin
            dec_bus       = '0;
            dec_bus.instr = head.instr;
            dec_bus.addr  = entry.addr;
            dec_bus.cnt   = entry.cnt;
            if (is_branch) begin
                dec_bus.pred   = predict_taken;
                dec_bus.br_pc  = head.pc;
                dec_bus.alt_pc = alt_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_pipeline) begin
            bus_q <= bubble_bus(BUBBLE_ADDR);
        end else if (cu_ready) begin
            bus_q <= dec_bus;
        end
    end

    assign idecode_cu_interface = bus_q;

`ifdef IDECODE_BPRED_EN
    logic       redirect_valid_q;
    logic [7:0] redirect_pc_q;

    // The FIFO is emptied on a taken issue, so the pulse cannot repeat next cycle.
    always_ff @(posedge clk) begin
        if (rst || flush_pipeline) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 8'd0;
        end else begin
            redirect_valid_q <= discard;
            redirect_pc_q    <= discard ? target : 8'd0;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
`else
    assign redirect_valid = 1'b0;
    assign redirect_pc    = 8'd0;
`endif

endmodule

// File: tb/tb_idecode_issue_unit.sv
// Scoreboard bench for idecode_issue_unit: a queue-based reference model predicts every cycle's outputs.
// Honours IDECODE_BPRED_EN the same way as the design.
module tb_idecode_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_pipeline;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [7:0]  fetch_pc;
    logic        fetch_ready;
    logic        cu_ready;
    logic        map_we;
    logic [5:0]  map_opcode;
    logic [10:0] map_data;
    logic [91:0] idecode_cu_interface;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [91:0] bus;
        logic        rv;
        logic [7:0]  rpc;
        logic        fr;
    } exp_t;

    exp_t        exp_q[$];
    int          map_m[64];
    logic [39:0] fifo_m[$];
    logic [91:0] cur_bus;
    logic        cur_rv;
    logic [7:0]  cur_rpc;

    localparam logic [91:0] BUBBLE = {1'b0, 8'h00, 8'h00, 32'h0, 3'd0, 8'hFF, 32'h0};

    idecode_issue_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush_pipeline       (flush_pipeline),
        .fetch_valid          (fetch_valid),
        .fetch_instr          (fetch_instr),
        .fetch_pc             (fetch_pc),
        .fetch_ready          (fetch_ready),
        .cu_ready             (cu_ready),
        .map_we               (map_we),
        .map_opcode           (map_opcode),
        .map_data             (map_data),
        .idecode_cu_interface (idecode_cu_interface),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [91:0] act, input logic [91:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the opcode/offset rules, using signed integer arithmetic.
    function automatic logic [91:0] decode_model(input logic [7:0] pc, input logic [31:0] instr,
                                                 output bit taken, output logic [7:0] tgt);
        int op, off, t, f;
        logic [91:0] b;
        op  = int'(instr >> 26);
        off = int'(instr & 32'hFF);
        if (off > 127) off = off - 256;
        t   = ((int'(pc) + off) % 256 + 256) % 256;
        f   = (int'(pc) + 1) % 256;
        taken = 1'b0;
`ifdef IDECODE_BPRED_EN
        taken = (op == 4) && (off < 0);
`endif
        tgt = 8'(t);
        b = '0;
        b[31:0]  = instr;
        b[39:32] = 8'(map_m[op] & 255);
        b[42:40] = 3'((map_m[op] >> 8) & 7);
        if (op == 4) begin
            b[91]    = taken;
            b[90:83] = pc;
            b[82:75] = taken ? 8'(f) : 8'(t);
        end
        return b;
    endfunction

    task automatic model_step();
        exp_t        e;
        logic [39:0] h;
        bit          taken;
        logic [7:0]  tgt;
        bit          push_ok;
        if (rst) begin
            for (int i = 0; i < 64; i++) map_m[i] = 255;
            fifo_m.delete();
            cur_bus = BUBBLE;
            cur_rv  = 1'b0;
            cur_rpc = 8'h00;
        end else begin
            push_ok = fetch_valid && (fifo_m.size() < 2);
            cur_rv  = 1'b0;
            cur_rpc = 8'h00;
            if (flush_pipeline) begin
                fifo_m.delete();
                cur_bus = BUBBLE;
            end else begin
                if (cu_ready) begin
                    if (fifo_m.size() > 0) begin
                        h = fifo_m.pop_front();
                        cur_bus = decode_model(h[39:32], h[31:0], taken, tgt);
                        if (taken) begin
                            fifo_m.delete();
                            push_ok = 1'b0;
                            cur_rv  = 1'b1;
                            cur_rpc = tgt;
                        end
                    end else begin
                        cur_bus = BUBBLE;
                    end
                end
                if (push_ok) fifo_m.push_back({fetch_pc, fetch_instr});
            end
            if (map_we) map_m[map_opcode] = int'(map_data);
        end
        e.bus = cur_bus;
        e.rv  = cur_rv;
        e.rpc = cur_rpc;
        e.fr  = (fifo_m.size() < 2);
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("bus", idecode_cu_interface, e.bus);
            check("redirect_valid", 92'(redirect_valid), 92'(e.rv));
            check("redirect_pc", 92'(redirect_pc), 92'(e.rpc));
            check("fetch_ready", 92'(fetch_ready), 92'(e.fr));
        end
    end

    // One call = one clock cycle with these inputs.
    task automatic apply(input bit fv, input logic [31:0] ins, input logic [7:0] pc, input bit cr,
                         input bit fl, input bit we, input logic [5:0] mop, input logic [10:0] md);
        @(negedge clk);
        rst            = 1'b0;
        fetch_valid    = fv;
        fetch_instr    = ins;
        fetch_pc       = pc;
        cu_ready       = cr;
        flush_pipeline = fl;
        map_we         = we;
        map_opcode     = mop;
        map_data       = md;
    endtask

    task automatic idle(input bit cr);
        apply(1'b0, 32'h0, 8'h0, cr, 1'b0, 1'b0, 6'h0, 11'h0);
    endtask

    task automatic push(input logic [31:0] ins, input logic [7:0] pc, input bit cr);
        apply(1'b1, ins, pc, cr, 1'b0, 1'b0, 6'h0, 11'h0);
    endtask

    initial begin
        logic [31:0] ins;
        int          r;
        rst = 1'b1; flush_pipeline = 1'b0; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
        cu_ready = 1'b0; map_we = 1'b0; map_opcode = '0; map_data = '0;
        repeat (3) @(posedge clk);

        // Idle after reset: bubbles, fetch_ready high.
        repeat (4) idle(1'b1);

        // Mapped opcode 1 issues with its map entry.
        apply(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1, 6'h01, {3'd3, 8'h20});
        push(32'h0400_0000, 8'h10, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: fill FIFO, third offer refused until space frees.
        push(32'h0400_0011, 8'h20, 1'b0);
        push(32'h0400_0012, 8'h21, 1'b0);
        push(32'h0400_0013, 8'h22, 1'b0);
        push(32'h0400_0013, 8'h22, 1'b0);
        push(32'h0400_0013, 8'h22, 1'b1);
        push(32'h0400_0013, 8'h22, 1'b1);
        repeat (3) idle(1'b1);

        // Backward branch with a younger entry behind it.
        push(32'h1000_00FC, 8'h05, 1'b0);
        push(32'h0400_0001, 8'h06, 1'b0);
        repeat (3) idle(1'b1);

        // Forward branch at the top of the address space.
        push(32'h1000_0002, 8'hFF, 1'b0);
        repeat (2) idle(1'b1);

        // Flush with a full FIFO and a simultaneous fetch offer.
        push(32'h0400_0021, 8'h40, 1'b0);
        push(32'h0400_0022, 8'h41, 1'b0);
        apply(1'b1, 32'h0400_0023, 8'h42, 1'b1, 1'b1, 1'b0, 6'h0, 11'h0);
        repeat (2) idle(1'b1);
        push(32'h0400_0000, 8'h30, 1'b0);
        idle(1'b1);

        // Map write in the same cycle as decode of that opcode uses the old entry.
        push(32'h0400_0000, 8'h31, 1'b0);
        apply(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b1, 6'h01, {3'd1, 8'h40});
        push(32'h0400_0000, 8'h32, 1'b0);
        repeat (2) idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 9));
            ins = $urandom();
            if (r < 4)      ins[31:26] = 6'h04;
            else if (r < 7) ins[31:26] = 6'h01;
            else if (r < 8) ins[31:26] = 6'($urandom_range(0, 7));
            apply($urandom_range(0, 9) < 7, ins, 8'($urandom()), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 9) == 0,
                  6'($urandom_range(0, 7)), 11'($urandom()));
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
        end

        repeat (4) idle(1'b1);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
